// File: rtl/coder_deinterleaver.sv
// QPP coder deinterleaver: loads a K-bit interleaved block into RAM at pi(j), then drains it in natural order.
// Optional build macro CODER_DEINT_STATUS_EN adds a blocks_done completion counter output.
module coder_deinterleaver #(
    parameter int RAM_DEPTH = 6144
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        K_eq_6144,
    input  logic        in_valid,
    input  logic        in_bit,
    output logic        in_ready,
    output logic        out_valid,
    output logic        out_bit,
    input  logic        out_ready,
    output logic        busy
`ifdef CODER_DEINT_STATUS_EN
    ,
    output logic [15:0] blocks_done
`endif
);

    typedef enum logic [1:0] {IDLE, LOAD, PREFETCH, DRAIN} state_t;

    state_t      state_q, state_d;
    logic [12:0] j_q, j_d;
    logic [12:0] n_q, n_d;
    logic [12:0] pi_q, pi_d;
    logic [12:0] g_q, g_d;
    logic        k6144_q, k6144_d;

    logic        mem [RAM_DEPTH];
    logic        rdata_q;
    logic        wr_en;
    logic [12:0] wr_addr;
    logic        rd_en;
    logic [12:0] rd_addr;
    logic        done;

    logic [12:0] k_mod;
    logic [12:0] k_last;
    logic [12:0] two_f2;

    // Sum of two residues can reach 2K-2, so the add is carried in 14 bits before the single subtract.
    function automatic logic [12:0] mod_add(input logic [12:0] a, input logic [12:0] b,
                                            input logic [12:0] k);
        logic [13:0] s;
        s = {1'b0, a} + {1'b0, b};
        if (s >= {1'b0, k}) s = s - {1'b0, k};
        return s[12:0];
    endfunction

    assign k_mod  = k6144_q ? 13'd6144 : 13'd1056;
    assign k_last = k6144_q ? 13'd6143 : 13'd1055;
    assign two_f2 = k6144_q ? 13'd960  : 13'd132;
    assign busy   = (state_q != IDLE);

    always_comb begin
        state_d   = state_q;
        j_d       = j_q;
        n_d       = n_q;
        pi_d      = pi_q;
        g_d       = g_q;
        k6144_d   = k6144_q;
        wr_en     = 1'b0;
        wr_addr   = pi_q;
        rd_en     = 1'b0;
        rd_addr   = 13'd0;
        done      = 1'b0;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        out_bit   = 1'b0;
        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    // pi(0)=0 is written now; preload pi(1)=g(0) and g(1) for the new block size.
                    k6144_d = K_eq_6144;
                    wr_en   = 1'b1;
                    wr_addr = 13'd0;
                    j_d     = 13'd1;
                    pi_d    = K_eq_6144 ? 13'd743  : 13'd83;
                    g_d     = K_eq_6144 ? 13'd1703 : 13'd215;
                    state_d = LOAD;
                end
            end
            LOAD: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    wr_en   = 1'b1;
                    wr_addr = pi_q;
                    if (j_q == k_last) begin
                        j_d     = 13'd0;
                        pi_d    = 13'd0;
                        g_d     = 13'd0;
                        state_d = PREFETCH;
                    end else begin
                        j_d  = j_q + 13'd1;
                        pi_d = mod_add(pi_q, g_q, k_mod);
                        g_d  = mod_add(g_q, two_f2, k_mod);
                    end
                end
            end
            PREFETCH: begin
                rd_en   = 1'b1;
                rd_addr = 13'd0;
                n_d     = 13'd0;
                state_d = DRAIN;
            end
            DRAIN: begin
                out_valid = 1'b1;
                out_bit   = rdata_q;
                if (out_ready) begin
                    if (n_q == k_last) begin
                        n_d     = 13'd0;
                        done    = 1'b1;
                        state_d = IDLE;
                    end else begin
                        n_d     = n_q + 13'd1;
                        rd_en   = 1'b1;
                        rd_addr = n_q + 13'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            j_q     <= 13'd0;
            n_q     <= 13'd0;
            pi_q    <= 13'd0;
            g_q     <= 13'd0;
            k6144_q <= 1'b0;
        end else begin
            state_q <= state_d;
            j_q     <= j_d;
            n_q     <= n_d;
            pi_q    <= pi_d;
            g_q     <= g_d;
            k6144_q <= k6144_d;
        end
    end

    // Block RAM: one write port for loading, one synchronous read port for draining.
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_addr] <= in_bit;
        if (rd_en) rdata_q <= mem[rd_addr];
    end

`ifdef CODER_DEINT_STATUS_EN
    logic [15:0] blocks_done_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)     blocks_done_q <= 16'd0;
        else if (done) blocks_done_q <= blocks_done_q + 16'd1;
    end

    assign blocks_done = blocks_done_q;
`endif

endmodule

// File: tb/tb_coder_deinterleaver.sv
// Directed bench for coder_deinterleaver: single-bit placement, all-ones, round trips, gaps, reset and back-to-back blocks.
module tb_coder_deinterleaver;

    logic clk = 1'b0;
    logic reset, K_eq_6144, in_valid, in_bit, in_ready, out_valid, out_bit, out_ready, busy;
`ifdef CODER_DEINT_STATUS_EN
    logic [15:0] blocks_done;
`endif

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int last_hs = 0;
    bit cin  [6144];
    bit expv [6144];
    bit got  [6144];
    bit orig [6144];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    coder_deinterleaver #(.RAM_DEPTH(6144)) dut (
        .clk(clk), .reset(reset), .K_eq_6144(K_eq_6144),
        .in_valid(in_valid), .in_bit(in_bit), .in_ready(in_ready),
        .out_valid(out_valid), .out_bit(out_bit), .out_ready(out_ready),
        .busy(busy)
`ifdef CODER_DEINT_STATUS_EN
        , .blocks_done(blocks_done)
`endif
    );

    function automatic int qpp(input int j, input int K, input int f1, input int f2);
        longint t;
        t = (longint'(f1) * j + longint'(f2) * j * j) % K;
        return int'(t);
    endfunction

    task automatic clear_all();
        for (int i = 0; i < 6144; i++) begin
            cin[i] = 1'b0;
            expv[i] = 1'b0;
            got[i] = 1'b0;
        end
    endtask

    // Random original block c, interleaved c'[j] = c[pi(j)]; deinterleaver must return c.
    task automatic build_round_trip(input int K);
        int f1, f2;
        f1 = (K == 6144) ? 263 : 17;
        f2 = (K == 6144) ? 480 : 66;
        clear_all();
        for (int i = 0; i < K; i++) orig[i] = 1'($urandom_range(0, 1));
        for (int j = 0; j < K; j++) cin[j] = orig[qpp(j, K, f1, f2)];
        for (int i = 0; i < K; i++) expv[i] = orig[i];
    endtask

    task automatic send(input bit k6144, input int K, input int nsend, input bit gaps, input bit flip);
        int j = 0;
        int guard = 0;
        while (j < nsend && guard < 4 * K + 50) begin
            @(negedge clk);
            guard++;
            K_eq_6144 = (flip && j > 0) ? ~k6144 : k6144;
            in_valid  = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
            in_bit    = cin[j];
            if (in_valid && in_ready) begin
                j++;
                last_hs = cyc + 1;
            end
        end
        checks++;
        if (j != nsend) begin
            errors++;
            $display("FAIL send_accept: accepted %0d bits, wanted %0d", j, nsend);
        end
    endtask

    task automatic recv(input int K, input bit gaps, input string name);
        int n = 0, guard = 0, first = -1, mism = 0, firstbad = -1, unstable = 0, rdy_bad = 0;
        bit hold = 1'b0, hbit = 1'b0;
        out_ready = 1'b0;
        while (n < K && guard < 4 * K + 50) begin
            @(negedge clk);
            guard++;
            in_valid = 1'b0;
            if (in_ready) rdy_bad++;
            if (hold && (!out_valid || out_bit !== hbit)) unstable++;
            if (out_valid && first < 0) first = cyc;
            out_ready = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
            if (out_valid && out_ready) begin
                got[n] = out_bit;
                n++;
                hold = 1'b0;
            end else begin
                hold = out_valid;
                hbit = out_bit;
            end
        end
        for (int i = 0; i < K; i++) begin
            if (got[i] !== expv[i]) begin
                if (firstbad < 0) firstbad = i;
                mism++;
            end
        end
        checks++;
        if (n != K) begin
            errors++;
            $display("FAIL %s count: received %0d bits, wanted %0d", name, n, K);
        end
        checks++;
        if (mism != 0) begin
            errors++;
            $display("FAIL %s data: %0d wrong bits, first n=%0d got %0b want %0b",
                     name, mism, firstbad, got[firstbad], expv[firstbad]);
        end
        checks++;
        if (unstable != 0) begin
            errors++;
            $display("FAIL %s hold: %0d unstable stalled cycles, wanted 0", name, unstable);
        end
        checks++;
        if (rdy_bad != 0) begin
            errors++;
            $display("FAIL %s in_ready_low: high on %0d output-phase cycles, wanted 0", name, rdy_bad);
        end
        checks++;
        if (first - last_hs != 1) begin
            errors++;
            $display("FAIL %s latency: out_valid %0d edges after last input edge, wanted 1", name, first - last_hs);
        end
        @(negedge clk);
        out_ready = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s end_idle: out_valid=%0b busy=%0b in_ready=%0b, wanted 0 0 1",
                     name, out_valid, busy, in_ready);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; K_eq_6144 = 1'b0; in_valid = 1'b0; in_bit = 1'b0; out_ready = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_bit !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: in_ready=%0b out_valid=%0b out_bit=%0b busy=%0b, wanted 1 0 0 0",
                     in_ready, out_valid, out_bit, busy);
        end
`ifdef CODER_DEINT_STATUS_EN
        checks++;
        if (blocks_done !== 16'd0) begin
            errors++;
            $display("FAIL reset_blocks_done: got %0d want 0", blocks_done);
        end
`endif
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_single_k1056();
        clear_all(); cin[1] = 1'b1; expv[83] = 1'b1;
        send(1'b0, 1056, 1056, 1'b0, 1'b0);
        recv(1056, 1'b0, "k1056_j1");
        clear_all(); cin[2] = 1'b1; expv[298] = 1'b1;
        send(1'b0, 1056, 1056, 1'b0, 1'b0);
        recv(1056, 1'b0, "k1056_j2");
    endtask

    task automatic test_k6144();
        clear_all(); cin[1] = 1'b1; expv[743] = 1'b1;
        send(1'b1, 6144, 6144, 1'b0, 1'b0);
        recv(6144, 1'b0, "k6144_j1");
        clear_all();
        for (int i = 0; i < 6144; i++) begin
            cin[i] = 1'b1;
            expv[i] = 1'b1;
        end
        send(1'b1, 6144, 6144, 1'b0, 1'b0);
        recv(6144, 1'b0, "k6144_ones");
    endtask

    task automatic test_round_trip_size_flip();
        build_round_trip(1056);
        send(1'b0, 1056, 1056, 1'b0, 1'b1);
        recv(1056, 1'b0, "rt1056_flip");
    endtask

    task automatic test_gaps();
        build_round_trip(1056);
        send(1'b0, 1056, 1056, 1'b1, 1'b0);
        recv(1056, 1'b1, "gaps1056");
    endtask

    task automatic test_reset_mid();
        clear_all();
        send(1'b1, 6144, 500, 1'b0, 1'b0);
        @(negedge clk);
        in_valid = 1'b0;
        checks++;
        if (busy !== 1'b1 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL mid_load: busy=%0b in_ready=%0b, wanted 1 1", busy, in_ready);
        end
        #2 reset = 1'b1;
        #1;
        checks++;
        if (busy !== 1'b0 || in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL async_reset: busy=%0b in_ready=%0b out_valid=%0b, wanted 0 1 0", busy, in_ready, out_valid);
        end
        @(negedge clk);
        reset = 1'b0;
        build_round_trip(1056);
        send(1'b0, 1056, 1056, 1'b0, 1'b0);
        recv(1056, 1'b0, "after_reset");
`ifdef CODER_DEINT_STATUS_EN
        checks++;
        if (blocks_done !== 16'd1) begin
            errors++;
            $display("FAIL blocks_done: got %0d want 1", blocks_done);
        end
`endif
    endtask

    task automatic test_back_to_back();
        build_round_trip(1056);
        send(1'b0, 1056, 1056, 1'b0, 1'b0);
        recv(1056, 1'b0, "b2b_first");
        build_round_trip(6144);
        send(1'b1, 6144, 6144, 1'b0, 1'b0);
        recv(6144, 1'b0, "b2b_second");
    endtask

    initial begin
        test_reset();
        test_single_k1056();
        test_k6144();
        test_round_trip_size_flip();
        test_gaps();
        test_reset_mid();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
